// File: rtl/tl_timed_ctrl.sv
// Timed two-road traffic light controller with all-red clearance on every handover.
// Optional night/fault flash mode is compiled in with `define TL_FLASH_EN.
module tl_timed_ctrl #(
    parameter int CNT_W      = 8,
    parameter int MAIN_MIN_G = 8,
    parameter int YEL_T      = 3,
    parameter int ALLRED_T   = 2,
    parameter int SIDE_MIN_G = 4,
    parameter int SIDE_MAX_G = 10,
    parameter int FLASH_HALF = 4
) (
    input  logic       clk,
    input  logic       Dreset_n,
    input  logic       Dss,
`ifdef TL_FLASH_EN
    input  logic       Dflash,
`endif
    output logic       forMR,
    output logic       forMY,
    output logic       forMG,
    output logic       forSR,
    output logic       forSY,
    output logic       forSG,
    output logic [2:0] eout
);

    typedef enum logic [2:0] {
        MAIN_G   = 3'd0,
        MAIN_Y   = 3'd1,
        ALLRED_A = 3'd2,
        SIDE_G   = 3'd3,
        SIDE_Y   = 3'd4,
        ALLRED_B = 3'd5,
        FLASH    = 3'd6
    } state_t;

    localparam logic [CNT_W-1:0] L_MAIN_MIN = CNT_W'(MAIN_MIN_G - 1);
    localparam logic [CNT_W-1:0] L_YEL      = CNT_W'(YEL_T - 1);
    localparam logic [CNT_W-1:0] L_ALLRED   = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] L_SIDE_MIN = CNT_W'(SIDE_MIN_G - 1);
    localparam logic [CNT_W-1:0] L_SIDE_MAX = CNT_W'(SIDE_MAX_G - 1);
`ifdef TL_FLASH_EN
    localparam logic [CNT_W-1:0] L_FL_HALF  = CNT_W'(FLASH_HALF);
    localparam logic [CNT_W-1:0] L_FL_WRAP  = CNT_W'(2 * FLASH_HALF - 1);
`endif

    // Illegal parameter sets leave a named marker in the elaborated hierarchy.
    if (FLASH_HALF < 1 || SIDE_MIN_G > SIDE_MAX_G || MAIN_MIN_G < 1 ||
        YEL_T < 1 || ALLRED_T < 1 || SIDE_MIN_G < 1) begin : g_bad_params
    end

    state_t           r_state;
    state_t           w_next;
    logic [CNT_W-1:0] r_cnt;
    logic [CNT_W-1:0] w_cnt_nxt;

    always_comb begin
        w_next = r_state;
        case (r_state)
            MAIN_G:   if (Dss && r_cnt >= L_MAIN_MIN) w_next = MAIN_Y;
            MAIN_Y:   if (r_cnt == L_YEL)             w_next = ALLRED_A;
            ALLRED_A: if (r_cnt == L_ALLRED)          w_next = SIDE_G;
            SIDE_G:   if ((!Dss && r_cnt >= L_SIDE_MIN) || r_cnt == L_SIDE_MAX)
                          w_next = SIDE_Y;
            SIDE_Y:   if (r_cnt == L_YEL)             w_next = ALLRED_B;
            ALLRED_B: if (r_cnt == L_ALLRED)          w_next = MAIN_G;
`ifdef TL_FLASH_EN
            FLASH:    if (!Dflash)                    w_next = ALLRED_B;
`endif
            default:                                  w_next = ALLRED_B;
        endcase
`ifdef TL_FLASH_EN
        if (Dflash) w_next = FLASH;
`endif
    end

    always_comb begin
        w_cnt_nxt = r_cnt;
        if (w_next != r_state)
            w_cnt_nxt = '0;
`ifdef TL_FLASH_EN
        else if (r_state == FLASH && r_cnt == L_FL_WRAP)
            w_cnt_nxt = '0;
`endif
        else if (r_cnt != '1)
            w_cnt_nxt = r_cnt + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (!Dreset_n) begin
            r_state <= MAIN_G;
            r_cnt   <= '0;
        end else begin
            r_state <= w_next;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Outputs decode the registered state only; no input reaches them directly.
    always_comb begin
        {forMR, forMY, forMG, forSR, forSY, forSG} = 6'b000000;
        eout = r_state;
        case (r_state)
            MAIN_G:             {forMG, forSR} = 2'b11;
            MAIN_Y:             {forMY, forSR} = 2'b11;
            ALLRED_A, ALLRED_B: {forMR, forSR} = 2'b11;
            SIDE_G:             {forMR, forSG} = 2'b11;
            SIDE_Y:             {forMR, forSY} = 2'b11;
`ifdef TL_FLASH_EN
            FLASH: begin
                forMY = (r_cnt < L_FL_HALF);
                forSY = (r_cnt < L_FL_HALF);
            end
`endif
            default:            {forMR, forSR} = 2'b11;
        endcase
    end

endmodule

// File: tb/tb_tl_timed_ctrl.sv
// Randomized bench for tl_timed_ctrl against a phase/duration reference model,
// plus directed scenarios for reset, max/min green and (with TL_FLASH_EN) flash mode.
module tb_tl_timed_ctrl;

    localparam int MMG = 8, YEL = 3, AR = 2, SMIN = 4, SMAX = 10, FH = 4;
`ifdef TL_FLASH_EN
    localparam bit FLASH_EN = 1'b1;
`else
    localparam bit FLASH_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       Dreset_n;
    logic       Dss;
    logic       Dflash;
    logic       forMR, forMY, forMG, forSR, forSY, forSG;
    logic [2:0] eout;
    wire  [5:0] w_lamps = {forMR, forMY, forMG, forSR, forSY, forSG};

    always #5 clk = ~clk;

    tl_timed_ctrl dut (
        .clk      (clk),
        .Dreset_n (Dreset_n),
        .Dss      (Dss),
`ifdef TL_FLASH_EN
        .Dflash   (Dflash),
`endif
        .forMR    (forMR),
        .forMY    (forMY),
        .forMG    (forMG),
        .forSR    (forSR),
        .forSY    (forSY),
        .forSG    (forSG),
        .eout     (eout)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input int obs, input int exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    // Model: current phase number and cycles spent in it.
    int m_ph = 0;
    int m_el = 0;

    function automatic int dur_done(int ph, int el, bit dss);
        case (ph)
            0:       return int'(dss && el >= MMG - 1);
            1, 4:    return int'(el >= YEL - 1);
            2, 5:    return int'(el >= AR - 1);
            3:       return int'((!dss && el >= SMIN - 1) || el >= SMAX - 1);
            default: return 1;
        endcase
    endfunction

    function automatic logic [5:0] exp_lamps(int ph, int el);
        logic [5:0] tab [0:5];
        tab[0] = 6'b001_100; tab[1] = 6'b010_100; tab[2] = 6'b100_100;
        tab[3] = 6'b100_001; tab[4] = 6'b100_010; tab[5] = 6'b100_100;
        if (ph == 6) return (el < FH) ? 6'b010_010 : 6'b000_000;
        return tab[ph];
    endfunction

    task automatic model_step(input bit r, input bit d, input bit f);
        if (!r) begin
            m_ph = 0; m_el = 0;
        end else if (f && FLASH_EN) begin
            if (m_ph != 6) begin m_ph = 6; m_el = 0; end
            else m_el = (m_el + 1) % (2 * FH);
        end else if (m_ph == 6) begin
            m_ph = 5; m_el = 0;
        end else if (dur_done(m_ph, m_el, d) != 0) begin
            m_ph = (m_ph + 1) % 6; m_el = 0;
        end else begin
            m_el++;
        end
    endtask

    // One clock: drive at the falling edge, check at the next falling edge.
    task automatic cyc(input bit r, input bit d, input bit f);
        Dreset_n = r; Dss = d; Dflash = f;
        model_step(r, d, f);
        @(negedge clk);
        chk("eout", int'(eout), m_ph);
        chk("lamps", int'(w_lamps), int'(exp_lamps(m_ph, m_el)));
    endtask

    function automatic int pat28(int k);
        int j;
        j = k % 28;
        if (j < 8)  return 0;
        if (j < 11) return 1;
        if (j < 13) return 2;
        if (j < 23) return 3;
        if (j < 26) return 4;
        return 5;
    endfunction

    task automatic wait_side_g(input int bound);
        int n;
        n = 0;
        while (eout != 3'd3 && n < bound) begin cyc(1, 1, 0); n++; end
        chk("reach_side_g", int'(eout), 3);
    endtask

    initial begin
        Dreset_n = 1'b0; Dss = 1'b0; Dflash = 1'b0;

        // Reset state
        cyc(0, 0, 0); cyc(0, 1, 0);
        chk("rst_eout", int'(eout), 0);
        chk("rst_lamps", int'(w_lamps), 6'b001_100);

        // Dss held high: fixed 28-cycle loop with max-green exit
        for (int k = 1; k <= 60; k++) begin
            cyc(1, 1, 0);
            chk("loop28", int'(eout), pat28(k));
        end

        // Reset mid-run for 2 edges
        cyc(0, 1, 0);
        chk("midrst_eout", int'(eout), 0);
        chk("midrst_lamps", int'(w_lamps), 6'b001_100);
        cyc(0, 1, 0);

        // Dss low: main green indefinitely
        for (int k = 0; k < 200; k++) cyc(1, 0, 0);
        chk("idle_main_g", int'(eout), 0);

        // Short request: 8 main green, 4 side green, 22-cycle loop
        cyc(0, 0, 0);
        for (int k = 1; k <= 22; k++) begin
            cyc(1, (k <= 8), 0);
            if (k == 7)  chk("mg_last", int'(eout), 0);
            if (k == 8)  chk("my_first", int'(eout), 1);
            if (k == 13) chk("sg_first", int'(eout), 3);
            if (k == 16) chk("sg_last", int'(eout), 3);
            if (k == 17) chk("sy_first", int'(eout), 4);
            if (k == 21) chk("arb_last", int'(eout), 5);
            if (k == 22) chk("loop22", int'(eout), 0);
        end

        // Reset in the 5th cycle of side green: straight to main green
        wait_side_g(40);
        for (int k = 0; k < 4; k++) cyc(1, 1, 0);
        chk("sg_5th", int'(eout), 3);
        cyc(0, 1, 0);
        chk("sgrst_eout", int'(eout), 0);
        chk("sgrst_mg", int'(forMG), 1);
        chk("sgrst_sg", int'(forSG), 0);
        chk("sgrst_sy", int'(forSY), 0);

`ifdef TL_FLASH_EN
        // Flash entered from side green, then released
        wait_side_g(40);
        for (int k = 0; k < 20; k++) begin
            cyc(1, 1, 1);
            chk("fl_eout", int'(eout), 6);
            chk("fl_my", int'(forMY), int'((k % 8) < 4));
            chk("fl_eq", int'(forSY), int'(forMY));
        end
        cyc(1, 1, 0); chk("fl_rel0", int'(eout), 5);
        cyc(1, 1, 0); chk("fl_rel1", int'(eout), 5);
        cyc(1, 1, 0); chk("fl_rel2", int'(eout), 0);
`endif

        // Randomized traffic with occasional reset / flash
        for (int k = 0; k < 3000; k++) begin
            bit r, d, f;
            r = ($urandom_range(0, 99) >= 2);
            d = ($urandom_range(0, 99) < 40);
            f = FLASH_EN && ($urandom_range(0, 99) < 3);
            cyc(r, d, f);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/tl_timed_ctrl.md
Name: tl_timed_ctrl

Overview:
- Parametrised, timed successor to the team's two-road traffic light controller: main road and side road, one side-road vehicle sensor.
- Adds programmable green/yellow/all-red durations, a minimum and maximum side-road green, and an all-red clearance interval on every handover.
- Sits between the sensor input logic and the lamp drivers; state code exported on eout for debug and monitoring.

Parameters:
CNT_W, 8, phase counter width; must satisfy 2^CNT_W > every duration below.
MAIN_MIN_G, 8, minimum main-road green in cycles (>=1).
YEL_T, 3, yellow duration in cycles, both roads (>=1).
ALLRED_T, 2, all-red clearance in cycles (>=1).
SIDE_MIN_G, 4, minimum side-road green in cycles (>=1, <=SIDE_MAX_G).
SIDE_MAX_G, 10, maximum side-road green in cycles.
FLASH_HALF, 4, flash half-period in cycles; used only with TL_FLASH_EN.

Ports:
clk  in  1  clock, rising edge.
Dreset_n  in  1  synchronous active-low reset.
Dss  in  1  side-road vehicle present; sampled each rising edge, already synchronous.
forMR, forMY, forMG  out  1 each  main-road red/yellow/green lamps.
forSR, forSY, forSG  out  1 each  side-road red/yellow/green lamps.
eout  out  3  current state code.
Dflash  in  1  flash-mode request; present only with TL_FLASH_EN.

Behaviour:
- Single clock. Reset is synchronous and active-low, checked at the rising edge with priority over all other inputs.
- Reset values: state MAIN_G, cnt=0, eout=0, forMG=1, forSR=1, all other lamps 0.
- cnt is an elapsed-cycle up-counter.
  - Cleared to 0 on every state change; otherwise +1 per cycle.
  - Saturates at all-ones.
- Lamps and eout are a pure decode of the registered state. No combinational path from any input to any output.
- Exactly one lamp per road is lit in every non-flash state.
- States (eout code, lamps, exit):
  - MAIN_G (0), MG+SR: go to MAIN_Y when cnt >= MAIN_MIN_G-1 and Dss=1. Otherwise hold; Dss=0 holds indefinitely.
  - MAIN_Y (1), MY+SR: go to ALLRED_A when cnt == YEL_T-1.
  - ALLRED_A (2), MR+SR: go to SIDE_G when cnt == ALLRED_T-1.
  - SIDE_G (3), MR+SG: go to SIDE_Y when (cnt >= SIDE_MIN_G-1 and Dss=0) or cnt == SIDE_MAX_G-1. The maximum-green limit wins even while Dss=1.
  - SIDE_Y (4), MR+SY: go to ALLRED_B when cnt == YEL_T-1.
  - ALLRED_B (5), MR+SR: go to MAIN_G when cnt == ALLRED_T-1.
- Consequence: a state exited on its timer alone lasts exactly its parameter in cycles.
- Dss is evaluated only in MAIN_G and SIDE_G; ignored in every other state. A Dss pulse during MAIN_Y, ALLRED or yellow states is not latched.
- Codes 6 and 7 are unreachable without TL_FLASH_EN. Any illegal state recovers to ALLRED_B on the next edge, cnt cleared.
- Reset asserted mid-phase: next edge gives MAIN_G, cnt=0, reset lamp pattern. No yellow or all-red on reset.

Optional Feature:
TL_FLASH_EN: night/fault flash mode.
- With macro:
  - Port Dflash exists. Dflash=1 at any edge (reset low excepted) moves the block to FLASH (eout=6) on that edge, cnt=0.
  - In FLASH, forMY and forSY are equal. Both are 1 for FLASH_HALF cycles, then 0 for FLASH_HALF cycles, repeating; cnt wraps at 2*FLASH_HALF-1.
  - All red and green lamps are 0 in FLASH.
  - Dflash=0 while in FLASH moves to ALLRED_B on the next edge, then normal sequencing resumes.
- Without macro: no Dflash port, FLASH state absent, FLASH_HALF unused.

Test Plan:
1. Hold Dreset_n=0 for 2 edges mid-run -> eout=0, forMG=1, forSR=1, others 0, at the first edge with reset low.
2. Defaults, Dss=1 constantly after reset -> eout sequence 0x8, 1x3, 2x2, 3x10 (max-green limit), 4x3, 5x2, repeating with a period of 28 cycles.
3. Dss=0 constantly for 200 cycles -> eout stays 0, forMG=1, forSR=1 throughout.
4. Dss=1 for cycles 0-7 of MAIN_G, then 0 -> main green lasts 8 cycles; side green exits after exactly 4 cycles (SIDE_MIN_G); total loop 22 cycles back to eout=0.
5. Dreset_n=0 in the 5th cycle of SIDE_G -> next edge eout=0, forMG=1, forSG=0. No yellow is shown.
6. (TL_FLASH_EN) Dflash=1 during SIDE_G for 20 cycles, then 0 -> eout=6; forMY=forSY=1 for 4 cycles, then 0 for 4 cycles; after release eout=5 for 2 cycles, then 0.
